// File: rtl/dmem_responder.sv
// dmem_responder: memory-side end of the CPU load/store interface.
// Accepts one request at a time over valid/ready. Each request is a word
// read or a byte-masked write into an internal array. The response comes
// back after WAIT_CYCLES wait states.
//
// Optional feature macro: DMEM_ERR_EN
//   defined   - misaligned or out-of-range addresses return rsp_err_o=1.
//               These requests do not touch the array.
//   undefined - the low two address bits and the upper address bits are
//               ignored, so addresses wrap modulo the array size.
//               rsp_err_o is held at 0.
//
// Ports
//   clk          system clock
//   rst_n        asynchronous active-low reset
//   req_valid_i  request valid
//   req_ready_o  responder can accept a request (only while idle)
//   req_we_i     1 = write, 0 = read
//   req_addr_i   byte address
//   req_wdata_i  write data
//   req_be_i     byte enables, bit i -> bits 8i+7:8i
//   rsp_valid_o  response valid
//   rsp_ready_i  requester accepts the response
//   rsp_rdata_o  read data (0 for writes and errors)
//   rsp_err_o    access error
//
// state  | meaning
// S_IDLE | ready for a request; the access happens here when WAIT_CYCLES==0
// S_WAIT | counting down wait states; the access happens when cnt goes 1->0
// S_RESP | response presented, held until rsp_ready_i
module dmem_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_we_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  input  logic [3:0]  req_be_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] rsp_rdata_o,
  output logic        rsp_err_o
);

  localparam int AW = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t      state, state_nxt;
  logic [3:0]  cnt;
  logic        cap_we;
  logic [31:0] cap_addr;
  logic [31:0] cap_wdata;
  logic [3:0]  cap_be;
  logic [31:0] mem [DEPTH_WORDS];

  logic          accept;
  logic          do_access;
  logic          acc_we;
  logic          acc_err;
  logic [31:0]   acc_addr;
  logic [31:0]   acc_wdata;
  logic [3:0]    acc_be;
  logic [AW-1:0] acc_idx;

  assign req_ready_o = (state == S_IDLE);
  assign rsp_valid_o = (state == S_RESP);
  assign accept      = req_valid_i & req_ready_o;

  // With zero wait states the access happens on the accept edge and uses the
  // live request. Otherwise it uses the copy captured on the accept edge.
  assign acc_we    = (state == S_IDLE) ? req_we_i    : cap_we;
  assign acc_addr  = (state == S_IDLE) ? req_addr_i  : cap_addr;
  assign acc_wdata = (state == S_IDLE) ? req_wdata_i : cap_wdata;
  assign acc_be    = (state == S_IDLE) ? req_be_i    : cap_be;
  assign acc_idx   = acc_addr[AW+1:2];

`ifdef DMEM_ERR_EN
  // The array size is a power of two, so any set bit above the index field
  // means the address is at or beyond DEPTH_WORDS*4.
  assign acc_err = (acc_addr[1:0] != 2'b00) | (acc_addr[31:AW+2] != '0);
`else
  logic unused_addr_bits;
  assign unused_addr_bits = ^{acc_addr[31:AW+2], acc_addr[1:0]};
  assign acc_err = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    do_access = 1'b0;
    case (state)
      S_IDLE: begin
        if (req_valid_i) begin
          if (WAIT_CYCLES == 0) begin
            do_access = 1'b1;
            state_nxt = S_RESP;
          end else begin
            state_nxt = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (cnt == 4'd1) begin
          do_access = 1'b1;
          state_nxt = S_RESP;
        end
      end
      S_RESP: begin
        if (rsp_ready_i) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      cnt         <= 4'd0;
      cap_we      <= 1'b0;
      cap_addr    <= 32'd0;
      cap_wdata   <= 32'd0;
      cap_be      <= 4'd0;
      rsp_rdata_o <= 32'd0;
      rsp_err_o   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        cnt       <= 4'(WAIT_CYCLES);
        cap_we    <= req_we_i;
        cap_addr  <= req_addr_i;
        cap_wdata <= req_wdata_i;
        cap_be    <= req_be_i;
      end else if (state == S_WAIT) begin
        cnt <= cnt - 4'd1;
      end
      if (do_access) begin
        rsp_err_o   <= acc_err;
        rsp_rdata_o <= (acc_we | acc_err) ? 32'd0 : mem[acc_idx];
      end
    end
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (do_access && acc_we && !acc_err) begin
      for (int b = 0; b < 4; b++) begin
        if (acc_be[b]) mem[acc_idx][8*b +: 8] <= acc_wdata[8*b +: 8];
      end
    end
  end

endmodule
